// File: rtl/mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | mem_port_arbiter: shares one memory port between fetch and load/store,    |
// | with alternating priority on contention and a watchdog abort.             |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module mem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [DW-1:0] if_rdata,
    output logic          if_done,
    output logic          if_err,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    input  logic [3:0]    ls_wmask,
    output logic [DW-1:0] ls_rdata,
    output logic          ls_done,
    output logic          ls_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic [3:0]    mem_wmask,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          busy,
    output logic          owner
);

    localparam int             WDW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] c_wd_max = WDW'(TIMEOUT);
    localparam bit             c_wd_en  = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    state_t         r_state;
    logic           r_last_owner;
    logic [WDW-1:0] r_wd;

    logic           w_if_elig;
    logic           w_ls_elig;
    logic           w_grant_any;
    logic           w_grant_ls;
    logic [WDW-1:0] w_wd_inc;
    logic           w_abort;

    // A port whose done is pulsing this cycle is finishing, not re-requesting.
    assign w_if_elig   = if_req & ~if_done;
    assign w_ls_elig   = ls_req & ~ls_done;
    assign w_grant_any = w_if_elig | w_ls_elig;
    assign w_grant_ls  = w_ls_elig & (~w_if_elig | ~r_last_owner);

    assign w_wd_inc = (r_wd == c_wd_max) ? r_wd : r_wd + 1'b1;
    assign w_abort  = c_wd_en && !mem_ready && (w_wd_inc == c_wd_max);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b0;
            r_wd         <= '0;
            if_rdata     <= '0;
            if_done      <= 1'b0;
            if_err       <= 1'b0;
            ls_rdata     <= '0;
            ls_done      <= 1'b0;
            ls_err       <= 1'b0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wmask    <= '0;
            busy         <= 1'b0;
            owner        <= 1'b0;
        end else begin
            if_done <= 1'b0;
            if_err  <= 1'b0;
            ls_done <= 1'b0;
            ls_err  <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_any) begin
                        busy    <= 1'b1;
                        mem_req <= 1'b1;
                        r_wd    <= '0;
                        if (w_grant_ls) begin
                            owner        <= 1'b1;
                            r_last_owner <= 1'b1;
                            mem_we       <= ls_we;
                            mem_addr     <= ls_addr;
                            mem_wdata    <= ls_wdata;
                            mem_wmask    <= ls_wmask;
                            r_state      <= ST_BUSY_LS;
                        end else begin
                            owner        <= 1'b0;
                            r_last_owner <= 1'b0;
                            mem_we       <= 1'b0;
                            mem_addr     <= if_addr;
                            mem_wdata    <= '0;
                            mem_wmask    <= '0;
                            r_state      <= ST_BUSY_IF;
                        end
                    end
                end
                ST_BUSY_IF, ST_BUSY_LS: begin
                    // mem_ready outranks the watchdog when both land together.
                    if (mem_ready || w_abort) begin
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= ST_IDLE;
                        if (r_state == ST_BUSY_LS) begin
                            ls_done  <= 1'b1;
                            ls_err   <= ~mem_ready;
                            ls_rdata <= mem_ready ? mem_rdata : '0;
                        end else begin
                            if_done  <= 1'b1;
                            if_err   <= ~mem_ready;
                            if_rdata <= mem_ready ? mem_rdata : '0;
                        end
                    end else begin
                        r_wd <= w_wd_inc;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter.   |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_done;
    logic        if_err;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic [31:0] ls_rdata;
    logic        ls_done;
    logic        ls_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        owner;

    int checks   = 0;
    int failures = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(15)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .if_err    (if_err),
        .ls_req    (ls_req),
        .ls_we     (ls_we),
        .ls_addr   (ls_addr),
        .ls_wdata  (ls_wdata),
        .ls_wmask  (ls_wmask),
        .ls_rdata  (ls_rdata),
        .ls_done   (ls_done),
        .ls_err    (ls_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .busy      (busy),
        .owner     (owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        if_req    = 1'b0;
        if_addr   = '0;
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        ls_addr   = '0;
        ls_wdata  = '0;
        ls_wmask  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        clear_inputs();
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0h exp=0", mem_req); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0h exp=0", busy); end
        checks++; if (owner !== 1'b0) begin failures++; $display("FAIL reset_owner got=%0h exp=0", owner); end
        checks++; if ({if_done, if_err, ls_done, ls_err} !== 4'b0) begin failures++; $display("FAIL reset_done_err got=%b exp=0000", {if_done, if_err, ls_done, ls_err}); end
        checks++; if ((if_rdata | ls_rdata) !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h/%h exp=0", if_rdata, ls_rdata); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_single_fetch;
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL fetch_mem_req got=%0h exp=1", mem_req); end
        checks++; if (mem_addr !== 32'h100) begin failures++; $display("FAIL fetch_mem_addr got=%h exp=00000100", mem_addr); end
        checks++; if ({mem_we, owner, busy} !== 3'b001) begin failures++; $display("FAIL fetch_we_owner_busy got=%b exp=001", {mem_we, owner, busy}); end
        mem_ready = 1'b1;
        mem_rdata = 32'hDEADBEEF;
        tick();
        checks++; if (if_done !== 1'b1) begin failures++; $display("FAIL fetch_done got=%0h exp=1", if_done); end
        checks++; if (if_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL fetch_rdata got=%h exp=deadbeef", if_rdata); end
        checks++; if ({mem_req, if_err, ls_done} !== 3'b000) begin failures++; $display("FAIL fetch_done_cycle got=%b exp=000", {mem_req, if_err, ls_done}); end
        if_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        checks++; if ({if_done, mem_req} !== 2'b00) begin failures++; $display("FAIL fetch_after got=%b exp=00", {if_done, mem_req}); end
    endtask

    task automatic test_contention;
        do_reset();
        if_req  = 1'b1;
        if_addr = 32'h300;
        ls_req  = 1'b1;
        ls_addr = 32'h200;
        tick();
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL contend_first_owner got=%0h exp=1", owner); end
        checks++; if (mem_addr !== 32'h200) begin failures++; $display("FAIL contend_first_addr got=%h exp=00000200", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 32'hA5A50001;
        tick();
        checks++; if ({ls_done, if_done, mem_req} !== 3'b100) begin failures++; $display("FAIL contend_ls_done got=%b exp=100", {ls_done, if_done, mem_req}); end
        checks++; if (ls_rdata !== 32'hA5A50001) begin failures++; $display("FAIL contend_ls_rdata got=%h exp=a5a50001", ls_rdata); end
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        checks++; if ({mem_req, owner} !== 2'b10) begin failures++; $display("FAIL contend_fetch_grant got=%b exp=10", {mem_req, owner}); end
        checks++; if (mem_addr !== 32'h300) begin failures++; $display("FAIL contend_fetch_addr got=%h exp=00000300", mem_addr); end
        mem_ready = 1'b1;
        mem_rdata = 32'h0BADF00D;
        tick();
        checks++; if ({if_done, if_rdata} !== {1'b1, 32'h0BADF00D}) begin failures++; $display("FAIL contend_fetch_done got=%0h/%h exp=1/0badf00d", if_done, if_rdata); end
        if_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_alternation;
        logic exp_owner;
        do_reset();
        if_req    = 1'b1;
        if_addr   = 32'h400;
        ls_req    = 1'b1;
        ls_addr   = 32'h800;
        mem_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_owner = (i % 2 == 0);
            tick();
            checks++; if ({mem_req, owner} !== {1'b1, exp_owner}) begin failures++; $display("FAIL alt_owner[%0d] got=%b exp=%b", i, {mem_req, owner}, {1'b1, exp_owner}); end
            mem_rdata = 32'h1000 + i;
            tick();
            if (exp_owner) begin
                checks++; if ({ls_done, if_done, ls_rdata} !== {2'b10, 32'h1000 + i}) begin failures++; $display("FAIL alt_ls_done[%0d] got=%b/%h exp=10/%h", i, {ls_done, if_done}, ls_rdata, 32'h1000 + i); end
            end else begin
                checks++; if ({if_done, ls_done, if_rdata} !== {2'b10, 32'h1000 + i}) begin failures++; $display("FAIL alt_if_done[%0d] got=%b/%h exp=10/%h", i, {if_done, ls_done}, if_rdata, 32'h1000 + i); end
            end
        end
        if_req    = 1'b0;
        ls_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
        checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL alt_idle got=%0h exp=0", mem_req); end
    endtask

    task automatic test_store_wait;
        ls_req   = 1'b1;
        ls_we    = 1'b1;
        ls_addr  = 32'h40;
        ls_wdata = 32'h12345678;
        ls_wmask = 4'b0011;
        for (int i = 1; i <= 4; i++) begin
            tick();
            ls_addr  = 32'hFFF0;
            ls_wdata = 32'h0;
            checks++; if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wmask} !== {2'b11, 32'h40, 32'h12345678, 4'b0011})
                begin failures++; $display("FAIL store_hold[%0d] got=%b/%b/%h/%h/%b exp=1/1/40/12345678/0011", i, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask); end
            if (i == 4) begin
                mem_ready = 1'b1;
                mem_rdata = 32'hCAFE0000;
            end
        end
        tick();
        checks++; if ({ls_done, ls_err, mem_req} !== 3'b100) begin failures++; $display("FAIL store_done got=%b exp=100", {ls_done, ls_err, mem_req}); end
        checks++; if (ls_rdata !== 32'hCAFE0000) begin failures++; $display("FAIL store_rdata got=%h exp=cafe0000", ls_rdata); end
        ls_req    = 1'b0;
        ls_we     = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_watchdog;
        if_req  = 1'b1;
        if_addr = 32'h500;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL wd_mem_req[%0d] got=%0h exp=1", i, mem_req); end
        end
        tick();
        checks++; if ({if_done, if_err, mem_req} !== 3'b110) begin failures++; $display("FAIL wd_abort got=%b exp=110", {if_done, if_err, mem_req}); end
        checks++; if (if_rdata !== 32'h0) begin failures++; $display("FAIL wd_rdata got=%h exp=00000000", if_rdata); end
        if_req = 1'b0;
        tick();
        checks++; if ({if_done, if_err} !== 2'b00) begin failures++; $display("FAIL wd_pulse_len got=%b exp=00", {if_done, if_err}); end
        if_req = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL wd_late_req[%0d] got=%0h exp=1", i, mem_req); end
            if (i == 15) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h11112222;
            end
        end
        tick();
        checks++; if ({if_done, if_err, if_rdata} !== {2'b10, 32'h11112222}) begin failures++; $display("FAIL wd_late_ready got=%b/%h exp=10/11112222", {if_done, if_err}, if_rdata); end
        if_req    = 1'b0;
        mem_ready = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid;
        ls_req  = 1'b1;
        ls_addr = 32'h80;
        tick();
        checks++; if ({busy, owner} !== 2'b11) begin failures++; $display("FAIL rmid_busy_ls got=%b exp=11", {busy, owner}); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if ({mem_req, busy, owner} !== 3'b000) begin failures++; $display("FAIL rmid_async_clear got=%b exp=000", {mem_req, busy, owner}); end
        checks++; if ((if_rdata | ls_rdata) !== 32'h0) begin failures++; $display("FAIL rmid_rdata got=%h/%h exp=0", if_rdata, ls_rdata); end
        ls_req    = 1'b0;
        mem_ready = 1'b1;
        tick();
        checks++; if ({ls_done, ls_err} !== 2'b00) begin failures++; $display("FAIL rmid_no_done got=%b exp=00", {ls_done, ls_err}); end
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        if_req    = 1'b1;
        ls_req    = 1'b1;
        tick();
        checks++; if ({mem_req, owner} !== 2'b11) begin failures++; $display("FAIL rmid_regrant_ls got=%b exp=11", {mem_req, owner}); end
        mem_ready = 1'b1;
        mem_rdata = 32'h77;
        tick();
        checks++; if ({ls_done, ls_rdata} !== {1'b1, 32'h77}) begin failures++; $display("FAIL rmid_ls_done got=%0h/%h exp=1/00000077", ls_done, ls_rdata); end
        clear_inputs();
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=expired exp=finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_contention();
        test_alternation();
        test_store_wait();
        test_watchdog();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
